// File: rtl/jump_anim_if.sv
// Signal bundle between jump_anim_ctrl, the frame/button sources, the renderer
// and the game state machine.

interface jump_anim_if;
    logic       i_frame_tick;
    logic       i_press;
    logic       i_enable;
    logic [9:0] i_x_start;
    logic [9:0] o_x_man;
    logic [9:0] o_y_man;
    logic [3:0] o_squeeze_man;
    logic       o_busy;
    logic       o_land_valid;
    logic [9:0] o_land_x;

    modport master (
        output i_frame_tick, i_press, i_enable, i_x_start,
        input  o_x_man, o_y_man, o_squeeze_man, o_busy, o_land_valid, o_land_x
    );

    modport slave (
        input  i_frame_tick, i_press, i_enable, i_x_start,
        output o_x_man, o_y_man, o_squeeze_man, o_busy, o_land_valid, o_land_x
    );
endinterface

// File: rtl/jump_anim_ctrl.sv
// Frame-synchronous charge/jump sequencer for the jumping man's animation.
// Optional SQUEEZE_RECOVER_EN: squeeze springs back by 2 per frame during the jump.

module jump_anim_ctrl #(
    parameter int unsigned FRAME_DIV   = 4,
    parameter int unsigned X_PER_LEVEL = 10,
    parameter int unsigned JUMP_FRAMES = 16,
    parameter int unsigned Y_GAIN      = 1
) (
    input  logic       clk,
    input  logic       rst,
    jump_anim_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_JUMP
    } state_e;

`ifdef SQUEEZE_RECOVER_EN
    localparam bit RECOVER_EN = 1'b1;
`else
    localparam bit RECOVER_EN = 1'b0;
`endif

    localparam int unsigned JF_LOG2 = $clog2(JUMP_FRAMES);
    localparam logic [3:0]  FC_WRAP = 4'(FRAME_DIV);
    localparam logic [3:0]  SQ_MAX  = 4'd14;
    localparam logic [5:0]  T_LAST  = 6'(JUMP_FRAMES);
    localparam logic [9:0]  X_STEP  = 10'(X_PER_LEVEL);
    localparam logic [13:0] Y_MUL   = 14'(Y_GAIN);
    localparam logic [9:0]  PIX_MAX = 10'h3FF;

    state_e      state_q;
    logic        armed_q;
    logic [3:0]  fc_q;
    logic [3:0]  squeeze_q;
    logic [9:0]  d_q;
    logic [9:0]  x0_q;
    logic [5:0]  t_q;
    logic [9:0]  x_man_q;
    logic [9:0]  y_man_q;
    logic        busy_q;
    logic        land_valid_q;
    logic [9:0]  land_x_q;

    logic [5:0]  t_d;
    logic [3:0]  fc_d;
    logic [3:0]  sq_inc_d;
    logic [3:0]  sq_launch_d;
    logic [3:0]  sq_jump_d;
    logic [9:0]  d_launch_d;
    logic [14:0] dt_prod;
    logic [10:0] x_sum;
    logic [9:0]  x_jump_d;
    logic [13:0] y_prod;
    logic [9:0]  y_jump_d;

    // NOTE: every value is assigned on every pass through always_comb, so no latch can be inferred.
    always_comb begin
        t_d         = t_q + 6'd1;
        fc_d        = fc_q + 4'd1;
        sq_inc_d    = (squeeze_q == SQ_MAX) ? SQ_MAX : squeeze_q + 4'd1;
        sq_launch_d = RECOVER_EN ? squeeze_q : 4'd0;
        sq_jump_d   = (RECOVER_EN && squeeze_q > 4'd2) ? squeeze_q - 4'd2 : 4'd0;
        d_launch_d  = 10'(squeeze_q) * X_STEP;

        // Arc evaluated at the frame being entered (t+1); at t=JUMP_FRAMES it lands at x0+D, y=0.
        dt_prod  = 15'(d_q) * 15'(t_d);
        x_sum    = 11'(x0_q) + 11'(dt_prod >> JF_LOG2);
        x_jump_d = x_sum[10] ? PIX_MAX : x_sum[9:0];
        y_prod   = Y_MUL * 14'(t_d) * 14'(T_LAST - t_d);
        y_jump_d = (y_prod > 14'd1023) ? PIX_MAX : y_prod[9:0];
    end

    // NOTE: non-blocking assignments here so every branch reads the pre-edge register values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            fc_q         <= '0;
            squeeze_q    <= '0;
            d_q          <= '0;
            x0_q         <= '0;
            t_q          <= '0;
            x_man_q      <= '0;
            y_man_q      <= '0;
            busy_q       <= 1'b0;
            land_valid_q <= 1'b0;
            land_x_q     <= '0;
        end else begin
            land_valid_q <= 1'b0;
            busy_q       <= (state_q != ST_IDLE);

            // Re-arm needs a released button observed while idle, tick or not.
            if (state_q == ST_IDLE && !bus.i_press) begin
                armed_q <= 1'b1;
            end

            if (bus.i_frame_tick) begin
                unique case (state_q)
                    ST_IDLE: begin
                        x_man_q   <= bus.i_x_start;
                        y_man_q   <= '0;
                        squeeze_q <= '0;
                        if (bus.i_enable && bus.i_press && armed_q) begin
                            state_q <= ST_CHARGE;
                            fc_q    <= '0;
                            armed_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end

                    ST_CHARGE: begin
                        x_man_q <= bus.i_x_start;
                        if (!bus.i_enable) begin
                            state_q   <= ST_IDLE;
                            squeeze_q <= '0;
                            fc_q      <= '0;
                            busy_q    <= 1'b0;
                        end else if (!bus.i_press) begin
                            state_q   <= ST_JUMP;
                            d_q       <= d_launch_d;
                            x0_q      <= bus.i_x_start;
                            t_q       <= '0;
                            y_man_q   <= '0;
                            squeeze_q <= sq_launch_d;
                        end else if (fc_d == FC_WRAP) begin
                            fc_q      <= '0;
                            squeeze_q <= sq_inc_d;
                        end else begin
                            fc_q <= fc_d;
                        end
                    end

                    ST_JUMP: begin
                        x_man_q   <= x_jump_d;
                        y_man_q   <= y_jump_d;
                        squeeze_q <= sq_jump_d;
                        if (t_d == T_LAST) begin
                            state_q      <= ST_IDLE;
                            t_q          <= '0;
                            land_valid_q <= 1'b1;
                            land_x_q     <= x_jump_d;
                        end else begin
                            t_q <= t_d;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_x_man       = x_man_q;
    assign bus.o_y_man       = y_man_q;
    assign bus.o_squeeze_man = squeeze_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_land_valid  = land_valid_q;
    assign bus.o_land_x      = land_x_q;

endmodule

// File: tb/tb_jump_anim_ctrl.sv
// Self-checking bench for jump_anim_ctrl: directed scenarios plus randomized
// frames against a frame-level behavioural model of the animation rules.

module tb_jump_anim_ctrl;

    localparam int FD  = 4;
    localparam int XPL = 10;
    localparam int JF  = 16;
    localparam int YG  = 1;

`ifdef SQUEEZE_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_CHARGE = 1;
    localparam int M_JUMP   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    jump_anim_if bus ();

    jump_anim_ctrl #(
        .FRAME_DIV  (FD),
        .X_PER_LEVEL(XPL),
        .JUMP_FRAMES(JF),
        .Y_GAIN     (YG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame-level view of the animation
    int m_mode, m_armed, m_held, m_lvl, m_x0, m_t;
    int e_x, e_y, e_sq, e_busy, e_lv, e_lx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_armed = 0; m_held = 0; m_lvl = 0; m_x0 = 0; m_t = 0;
        e_x = 0; e_y = 0; e_sq = 0; e_busy = 0; e_lv = 0; e_lx = 0;
    endtask

    task automatic model_tick(input bit p, input bit en, input int xs);
        int d;
        e_lv = 0;
        case (m_mode)
            M_IDLE: begin
                e_x = xs; e_y = 0; e_sq = 0;
                if (!p) m_armed = 1;
                else if (en && m_armed == 1) begin
                    m_mode = M_CHARGE; m_held = 0; m_armed = 0;
                end
            end
            M_CHARGE: begin
                e_x = xs;
                if (!en) begin
                    m_mode = M_IDLE; e_sq = 0;
                end else if (!p) begin
                    m_lvl = imin(14, m_held / FD);
                    m_x0 = xs; m_t = 0; m_mode = M_JUMP;
                    e_y = 0; e_sq = RECOVER ? m_lvl : 0;
                end else begin
                    m_held++;
                    e_sq = imin(14, m_held / FD);
                end
            end
            default: begin
                m_t++;
                d = m_lvl * XPL;
                e_x = imin(1023, m_x0 + (d * m_t) / JF);
                e_y = imin(1023, YG * m_t * (JF - m_t));
                e_sq = RECOVER ? imax(0, m_lvl - 2 * m_t) : 0;
                if (m_t == JF) begin
                    e_lv = 1; e_lx = e_x; m_mode = M_IDLE;
                end
            end
        endcase
        e_busy = (m_mode != M_IDLE || e_lv == 1) ? 1 : 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_x"},    bus.o_x_man,       e_x);
        check({pfx, "_y"},    bus.o_y_man,       e_y);
        check({pfx, "_sq"},   bus.o_squeeze_man, e_sq);
        check({pfx, "_busy"}, bus.o_busy,        e_busy);
        check({pfx, "_lv"},   bus.o_land_valid,  e_lv);
        check({pfx, "_lx"},   bus.o_land_x,      e_lx);
    endtask

    // Called at a negedge; one frame tick, then gap tick-free cycles.
    task automatic step(input bit p, input bit en, input int xs, input int gap);
        bus.i_press      = p;
        bus.i_enable     = en;
        bus.i_x_start    = 10'(xs);
        bus.i_frame_tick = 1'b1;
        model_tick(p, en, xs);
        @(negedge clk);
        bus.i_frame_tick = 1'b0;
        check_outputs("tick");
        if (gap > 0 && m_mode == M_IDLE && !p) m_armed = 1;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_lv",   bus.o_land_valid, 0);
            check("gap_busy", bus.o_busy, (m_mode != M_IDLE) ? 1 : 0);
            check("gap_x",    bus.o_x_man, e_x);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.i_frame_tick = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
        end
        rst = 1'b0;
        bus.i_frame_tick = 1'b0;
        model_reset();
        check_outputs("rst");
    endtask

    bit r_p, r_en;
    int r_xs;

    initial begin
        rst = 1'b1;
        bus.i_frame_tick = 1'b0;
        bus.i_press      = 1'b0;
        bus.i_enable     = 1'b0;
        bus.i_x_start    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("por");
        rst = 1'b0;

        // Charge 24 frames at x=100, then a level-6 jump
        step(0, 1, 100, 1);
        step(1, 1, 100, 1);
        check("charge_busy", bus.o_busy, 1);
        repeat (24) step(1, 1, 100, 1);
        check("sq_after_24", bus.o_squeeze_man, 6);
        step(0, 1, 100, 1);
        repeat (8) step(0, 1, 100, 1);
        check("t8_x", bus.o_x_man, 130);
        check("t8_y", bus.o_y_man, 64);
        repeat (7) step(0, 1, 100, 0);
        step(0, 1, 100, 0);
        check("land_valid", bus.o_land_valid, 1);
        check("land_x_160", bus.o_land_x, 160);
        check("land_y", bus.o_y_man, 0);
        step(0, 1, 100, 0);
        check("land_pulse_once", bus.o_land_valid, 0);
        check("busy_after_land", bus.o_busy, 0);
        step(0, 1, 100, 1);

        // Saturated charge, then x saturation
        step(1, 1, 100, 1);
        repeat (100) step(1, 1, 100, 1);
        check("sq_sat", bus.o_squeeze_man, 14);
        step(0, 1, 100, 1);
        repeat (15) step(0, 1, 100, 1);
        step(0, 1, 100, 0);
        check("land_x_240", bus.o_land_x, 240);
        step(0, 1, 1000, 1);
        step(1, 1, 1000, 1);
        repeat (100) step(1, 1, 1000, 1);
        step(0, 1, 1000, 1);
        repeat (15) step(0, 1, 1000, 1);
        step(0, 1, 1000, 0);
        check("land_x_sat", bus.o_land_x, 1023);
        check("land_x_sat_man", bus.o_x_man, 1023);

        // Enable dropped on the 10th charge tick
        step(0, 1, 50, 1);
        step(1, 1, 50, 1);
        repeat (8) step(1, 1, 50, 1);
        step(1, 0, 50, 1);
        check("drop_sq", bus.o_squeeze_man, 0);
        check("drop_busy", bus.o_busy, 0);
        repeat (3) step(1, 1, 50, 1);
        check("drop_no_restart", bus.o_busy, 0);

        // Button held through landing: no re-charge until released in IDLE
        step(0, 1, 200, 1);
        step(1, 1, 200, 1);
        repeat (8) step(1, 1, 200, 1);
        step(0, 1, 200, 1);
        repeat (16) step(1, 1, 200, 1);
        repeat (20) step(1, 1, 200, 1);
        check("held_no_charge", bus.o_busy, 0);
        step(0, 1, 200, 1);
        step(1, 1, 200, 1);
        check("rearm_charge", bus.o_busy, 1);
        step(0, 1, 200, 1);
        repeat (16) step(0, 1, 200, 1);
        check("lvl0_land_x", bus.o_land_x, 200);

        // Squeeze behaviour over the first jump frames
        step(1, 1, 300, 1);
        repeat (24) step(1, 1, 300, 1);
        step(0, 1, 300, 1);
        check("sq_launch", bus.o_squeeze_man, RECOVER ? 6 : 0);
        step(0, 1, 300, 1);
        check("sq_j1", bus.o_squeeze_man, RECOVER ? 4 : 0);
        step(0, 1, 300, 1);
        check("sq_j2", bus.o_squeeze_man, RECOVER ? 2 : 0);
        step(0, 1, 300, 1);
        check("sq_j3", bus.o_squeeze_man, 0);
        repeat (13) step(0, 1, 300, 1);

        // Reset in the middle of a jump, with the tick held high
        step(1, 1, 300, 1);
        repeat (8) step(1, 1, 300, 1);
        step(0, 1, 300, 1);
        repeat (5) step(0, 1, 300, 1);
        do_reset(3);
        repeat (20) step(1, 1, 300, 1);
        check("post_rst_idle", bus.o_busy, 0);

        // Randomized frames
        r_p = 1'b0;
        r_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) r_p = ~r_p;
            r_en = ($urandom_range(0, 49) != 0);
            r_xs = int'($urandom_range(0, 1023));
            step(r_p, r_en, r_xs, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
